// File: rtl/opsum_ppu_pkg.sv
// Shared types, widths and the int8 saturation helper for the opsum post-processing unit.
package opsum_ppu_pkg;

  localparam int DATA_BITS = 32;
  localparam int OUT_BITS  = 8;
  localparam int PACK      = DATA_BITS / OUT_BITS;
  localparam int CNT_BITS  = 10;
  // Headroom for sign, ReLU'd value and the rounding bias before the shift.
  localparam int ACC_BITS  = 34;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ppu_state_t;

  // Clamp a shifted intermediate into the signed 8-bit range.
  function automatic logic signed [OUT_BITS-1:0] sat_i8(input logic signed [ACC_BITS-1:0] r);
    if (r > 34'sd127) begin
      return 8'sh7F;
    end else if (r < -34'sd128) begin
      return 8'sh80;
    end else begin
      return r[OUT_BITS-1:0];
    end
  endfunction

endpackage

// File: rtl/opsum_ppu_if.sv
// Opsum input stream and packed ofmap output stream of the PPU.
interface opsum_ppu_if;
  import opsum_ppu_pkg::*;

  logic signed [DATA_BITS-1:0] opsum;
  logic                        opsum_valid;
  logic                        opsum_ready;
  logic        [DATA_BITS-1:0] ofmap;
  logic        [PACK-1:0]      ofmap_keep;
  logic                        ofmap_valid;
  logic                        ofmap_ready;

  modport master (
    output opsum, opsum_valid, ofmap_ready,
    input  opsum_ready, ofmap, ofmap_keep, ofmap_valid
  );

  modport slave (
    input  opsum, opsum_valid, ofmap_ready,
    output opsum_ready, ofmap, ofmap_keep, ofmap_valid
  );

endinterface

// File: rtl/opsum_ppu_requant.sv
// Combinational requantisation: optional ReLU, round-half-up arithmetic shift,
// int8 saturation and re-offset to the uint8 ifmap encoding.
module opsum_ppu_requant
  import opsum_ppu_pkg::*;
(
  input  logic signed [DATA_BITS-1:0] opsum,
  input  logic        [4:0]           shift,
  input  logic                        relu,
  output logic        [OUT_BITS-1:0]  byte_o
);

  logic signed [ACC_BITS-1:0] v;
  logic signed [ACC_BITS-1:0] bias;
  logic signed [ACC_BITS-1:0] r;
  logic signed [OUT_BITS-1:0] s;

  // ReLU, add half an LSB of the result, shift arithmetically, then saturate.
  always_comb begin
    v      = (relu && opsum[DATA_BITS-1]) ? '0
           : {{(ACC_BITS-DATA_BITS){opsum[DATA_BITS-1]}}, opsum};
    bias   = (shift == 5'd0) ? '0 : (34'sd1 <<< (shift - 5'd1));
    r      = (v + bias) >>> shift;
    s      = sat_i8(r);
    byte_o = s ^ 8'h80;
  end

endmodule

// File: rtl/opsum_ppu.sv
// Opsum post-processing unit: requantises each accepted psum to a uint8 byte
// and packs four bytes per ofmap word, with a pass-level IDLE/RUN/DRAIN FSM.
module opsum_ppu
  import opsum_ppu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ppu_en,
  input  logic [4:0]          cfg_shift,
  input  logic                cfg_relu,
  input  logic [CNT_BITS-1:0] cfg_num,
  opsum_ppu_if.slave          bus,
  output logic                done
);

  localparam int PCW = $clog2(PACK);
  localparam logic [PCW-1:0] LANE_LAST = PCW'(PACK - 1);

  ppu_state_t          state_q, state_d;
  logic [4:0]          shift_q, shift_d;
  logic                relu_q, relu_d;
  logic [CNT_BITS-1:0] num_q, num_d;
  logic [CNT_BITS-1:0] elem_cnt_q, elem_cnt_d;
  logic [PCW-1:0]      pack_cnt_q, pack_cnt_d;
  logic [DATA_BITS-1:0] pack_buf_q, pack_buf_d;
  logic [PACK-1:0]     pack_keep_q, pack_keep_d;
  logic [DATA_BITS-1:0] ofmap_q, ofmap_d;
  logic [PACK-1:0]     keep_q, keep_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;

  logic                out_free;
  logic                accept;
  logic                last;
  logic [CNT_BITS-1:0] elem_next;
  logic [OUT_BITS-1:0] byte_w;
  logic [DATA_BITS-1:0] word_w;
  logic [PACK-1:0]     keep_w;

  opsum_ppu_requant u_requant (
    .opsum  (bus.opsum),
    .shift  (shift_q),
    .relu   (relu_q),
    .byte_o (byte_w)
  );

  // The output register is free when empty or being drained this cycle.
  assign out_free        = !valid_q || bus.ofmap_ready;
  assign bus.opsum_ready = (state_q == RUN) && out_free;
  assign accept          = bus.opsum_valid && bus.opsum_ready;
  assign elem_next       = elem_cnt_q + CNT_BITS'(1);
  assign last            = (elem_next == num_q);
  assign word_w          = pack_buf_q | (DATA_BITS'(byte_w) << (OUT_BITS * pack_cnt_q));
  assign keep_w          = pack_keep_q | (PACK'(1) << pack_cnt_q);

  assign bus.ofmap       = ofmap_q;
  assign bus.ofmap_keep  = keep_q;
  assign bus.ofmap_valid = valid_q;
  assign done            = done_q;

  // Next-state logic: pass control, byte packing and output-register handoff.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    relu_d      = relu_q;
    num_d       = num_q;
    elem_cnt_d  = elem_cnt_q;
    pack_cnt_d  = pack_cnt_q;
    pack_buf_d  = pack_buf_q;
    pack_keep_d = pack_keep_q;
    ofmap_d     = ofmap_q;
    keep_d      = keep_q;
    valid_d     = valid_q;
    done_d      = 1'b0;

    if (valid_q && bus.ofmap_ready) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (ppu_en) begin
          shift_d     = cfg_shift;
          relu_d      = cfg_relu;
          num_d       = cfg_num;
          elem_cnt_d  = '0;
          pack_cnt_d  = '0;
          pack_buf_d  = '0;
          pack_keep_d = '0;
          state_d     = (cfg_num == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          elem_cnt_d = elem_next;
          // A full or final word replaces whatever the consumer just took.
          if (pack_cnt_q == LANE_LAST || last) begin
            ofmap_d     = word_w;
            keep_d      = keep_w;
            valid_d     = 1'b1;
            pack_cnt_d  = '0;
            pack_buf_d  = '0;
            pack_keep_d = '0;
          end else begin
            pack_buf_d  = word_w;
            pack_keep_d = keep_w;
            pack_cnt_d  = pack_cnt_q + PCW'(1);
          end
          if (last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_free) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything, discarding partial words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      num_q       <= '0;
      elem_cnt_q  <= '0;
      pack_cnt_q  <= '0;
      pack_buf_q  <= '0;
      pack_keep_q <= '0;
      ofmap_q     <= '0;
      keep_q      <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      relu_q      <= relu_d;
      num_q       <= num_d;
      elem_cnt_q  <= elem_cnt_d;
      pack_cnt_q  <= pack_cnt_d;
      pack_buf_q  <= pack_buf_d;
      pack_keep_q <= pack_keep_d;
      ofmap_q     <= ofmap_d;
      keep_q      <= keep_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
    end
  end

endmodule
